// File: rtl/alu_issue.sv
// Issue stage in front of the ALU: decode, operand read, RAW/WAW scoreboard.
// Define ALU_ISSUE_IMM_PREFIX_EN to enable the IMM prefix instruction class.
module alu_issue #(
    parameter int BITS = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [15:0]     instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [3:0]      regA_sel,
    output logic [3:0]      regB_sel,
    input  logic [BITS-1:0] regA_data,
    input  logic [BITS-1:0] regB_data,
    input  logic            wb_valid,
    input  logic [3:0]      wb_reg,
    output logic [BITS-1:0] A,
    output logic [BITS-1:0] B,
    output logic [4:0]      aluOp,
    output logic            execute,
    output logic [3:0]      dest_reg,
    output logic            dest_we,
    output logic            illegal
);

    logic [BITS-1:0] a_q, a_d, b_q, b_d;
    logic [4:0]      op_q, op_d;
    logic [3:0]      dst_q, dst_d;
    logic            we_q, we_d;
    logic            exe_q, exe_d;
    logic            ill_q, ill_d;
    logic [15:0]     pend_q, pend_d;

    logic            is_pfx, is_rr, is_ri, is_ill;
    logic            op_we, hazard, accept, issue;
    logic [4:0]      op;
    logic [3:0]      dst, src;
    logic [BITS-1:0] imm;

    assign op       = instr[12:8];
    assign dst      = instr[7:4];
    assign src      = instr[3:0];
    assign regA_sel = dst;
    assign regB_sel = src;

    always_comb begin
        is_pfx = 1'b0;
        is_rr  = 1'b0;
        is_ri  = 1'b0;
        is_ill = 1'b0;
        unique casez (instr[15:12])
            4'b0000: ;
`ifdef ALU_ISSUE_IMM_PREFIX_EN
            4'b0001: is_pfx = 1'b1;
`endif
            4'b001?: is_rr  = 1'b1;
            4'b010?: is_ri  = 1'b1;
            default: is_ill = 1'b1;
        endcase
    end

    // Compares, branches and stores: ops that never write a register.
    always_comb begin
        op_we = 1'b1;
        case (op)
            5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15,
            5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26,
            5'd27, 5'd28, 5'd30, 5'd31: op_we = 1'b0;
            default: op_we = 1'b1;
        endcase
    end

    // dest is also source A, so the WAW check is covered by the RAW check.
    assign hazard      = (is_rr & (pend_q[dst] | pend_q[src]))
                       | (is_ri & pend_q[dst]);
    assign instr_ready = ~hazard;
    assign accept      = instr_valid & instr_ready;
    assign issue       = accept & (is_rr | is_ri);

`ifdef ALU_ISSUE_IMM_PREFIX_EN
    logic [11:0] pfx_q, pfx_d;
    logic        pfxv_q, pfxv_d;

    assign imm = pfxv_q ? BITS'({pfx_q, src}) : BITS'(src);

    always_comb begin
        pfx_d  = pfx_q;
        pfxv_d = pfxv_q;
        if (accept) begin
            pfxv_d = is_pfx;
            if (is_pfx) pfx_d = instr[11:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pfx_q  <= '0;
            pfxv_q <= 1'b0;
        end else begin
            pfx_q  <= pfx_d;
            pfxv_q <= pfxv_d;
        end
    end
`else
    assign imm = BITS'(src);
`endif

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        dst_d  = dst_q;
        we_d   = we_q;
        exe_d  = issue;
        ill_d  = accept & is_ill;
        pend_d = pend_q;
        if (wb_valid) pend_d[wb_reg] = 1'b0;
        if (issue) begin
            a_d   = regA_data;
            b_d   = is_rr ? regB_data : imm;
            op_d  = op;
            dst_d = dst;
            we_d  = op_we;
            if (op_we) pend_d[dst] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            dst_q  <= '0;
            we_q   <= 1'b0;
            exe_q  <= 1'b0;
            ill_q  <= 1'b0;
            pend_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            dst_q  <= dst_d;
            we_q   <= we_d;
            exe_q  <= exe_d;
            ill_q  <= ill_d;
            pend_q <= pend_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign aluOp    = op_q;
    assign dest_reg = dst_q;
    assign dest_we  = we_q;
    assign execute  = exe_q;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue (handles both prefix build options).
module tb_alu_issue;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  regA_sel, regB_sel;
    logic [15:0] regA_data, regB_data;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [15:0] A, B;
    logic [4:0]  aluOp;
    logic        execute;
    logic [3:0]  dest_reg;
    logic        dest_we;
    logic        illegal;

    always #5 CLK = ~CLK;

    alu_issue #(.BITS(16)) dut (
        .CLK(CLK), .RST(RST),
        .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .regA_sel(regA_sel), .regB_sel(regB_sel),
        .regA_data(regA_data), .regB_data(regB_data),
        .wb_valid(wb_valid), .wb_reg(wb_reg),
        .A(A), .B(B), .aluOp(aluOp), .execute(execute),
        .dest_reg(dest_reg), .dest_we(dest_we),
        .illegal(illegal)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] ins;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        wbv;
        logic [3:0]  wbr;
        logic        rdy;
        logic        exe;
        logic        ill;
        logic        we;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  op;
        logic [3:0]  d;
    } vec_t;

    int nvec = 0;
    int nbad = 0;
    int cur  = 0;

`ifdef ALU_ISSUE_IMM_PREFIX_EN
    localparam logic        PFX_ILL = 1'b0;
    localparam logic [15:0] PFX_B   = 16'hABC7;
`else
    localparam logic        PFX_ILL = 1'b1;
    localparam logic [15:0] PFX_B   = 16'h0007;
`endif

    function automatic vec_t mk(
        input logic rst, input logic vld, input logic [15:0] ins,
        input logic [15:0] ra, input logic [15:0] rb,
        input logic wbv, input logic [3:0] wbr,
        input logic rdy, input logic exe, input logic ill,
        input logic we, input logic [15:0] a, input logic [15:0] b,
        input logic [4:0] op, input logic [3:0] d);
        vec_t v;
        v.rst = rst; v.vld = vld; v.ins = ins; v.ra = ra; v.rb = rb;
        v.wbv = wbv; v.wbr = wbr; v.rdy = rdy; v.exe = exe;
        v.ill = ill; v.we = we; v.a = a; v.b = b; v.op = op; v.d = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL step %0d %s: got %h expected %h",
                     cur, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [15:0] w;
        @(negedge CLK);
        RST         = v.rst;
        instr_valid = v.vld;
        instr       = v.ins;
        regA_data   = v.ra;
        regB_data   = v.rb;
        wb_valid    = v.wbv;
        wb_reg      = v.wbr;
        #1;
        w = v.ins;
        chk("instr_ready", 16'(instr_ready), 16'(v.rdy));
        chk("regA_sel", 16'(regA_sel), 16'(w[7:4]));
        chk("regB_sel", 16'(regB_sel), 16'(w[3:0]));
        @(posedge CLK);
        #1;
        chk("execute", 16'(execute), 16'(v.exe));
        chk("illegal", 16'(illegal), 16'(v.ill));
        chk("dest_we", 16'(dest_we), 16'(v.we));
        chk("A", A, v.a);
        chk("B", B, v.b);
        chk("aluOp", 16'(aluOp), 16'(v.op));
        chk("dest_reg", 16'(dest_reg), 16'(v.d));
        cur++;
    endtask

    vec_t tbl[11];

    initial begin
        RST = 1'b1; instr = '0; instr_valid = 1'b0;
        regA_data = '0; regB_data = '0;
        wb_valid = 1'b0; wb_reg = '0;
        repeat (2) @(posedge CLK);

        //         rst vld ins      ra       rb       wbv wbr  rdy exe ill we A        B        op  d
        tbl[0]  = mk(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        tbl[1]  = mk(0, 1, 16'h2112, 16'h0005, 16'h0003, 0, 0, 1, 1, 0, 1, 16'h0005, 16'h0003, 1, 1);
        tbl[2]  = mk(0, 1, 16'h2C62, 16'h0010, 16'h0020, 0, 0, 1, 1, 0, 0, 16'h0010, 16'h0020, 12, 6);
        tbl[3]  = mk(0, 1, 16'h2231, 16'h0001, 16'h0002, 0, 0, 0, 0, 0, 0, 16'h0010, 16'h0020, 12, 6);
        tbl[4]  = mk(0, 1, 16'h0000, 16'h0000, 16'h0000, 1, 1, 1, 0, 0, 0, 16'h0010, 16'h0020, 12, 6);
        tbl[5]  = mk(0, 1, 16'h2231, 16'h0007, 16'h0009, 0, 0, 1, 1, 0, 1, 16'h0007, 16'h0009, 2, 3);
        tbl[6]  = mk(0, 1, 16'hF000, 16'h0000, 16'h0000, 0, 0, 1, 0, 1, 1, 16'h0007, 16'h0009, 2, 3);
        tbl[7]  = mk(0, 1, 16'h5057, 16'h1111, 16'hFFFF, 0, 0, 1, 1, 0, 1, 16'h1111, 16'h0007, 16, 5);
        tbl[8]  = mk(0, 1, 16'h4037, 16'h0042, 16'h0000, 1, 3, 0, 0, 0, 1, 16'h1111, 16'h0007, 16, 5);
        tbl[9]  = mk(0, 1, 16'h4037, 16'h0042, 16'h0000, 0, 0, 1, 1, 0, 1, 16'h0042, 16'h0007, 0, 3);
        tbl[10] = mk(0, 0, 16'h21D2, 16'h0099, 16'h0000, 0, 0, 1, 0, 0, 1, 16'h0042, 16'h0007, 0, 3);

        for (int i = 0; i < 11; i++) apply(tbl[i]);

        // prefix then two reg-imm ops: only the first picks up the prefix
        apply(mk(0, 1, 16'h1ABC, 16'h0000, 16'h0000, 0, 0, 1, 0, PFX_ILL, 1, 16'h0042, 16'h0007, 0, 3));
        apply(mk(0, 1, 16'h5077, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 1, 16'h0000, PFX_B, 16, 7));
        apply(mk(0, 1, 16'h5087, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 1, 16'h0000, 16'h0007, 16, 8));

        // CMP then ADD on the same register back to back
        apply(mk(0, 1, 16'h2C12, 16'h0003, 16'h0004, 1, 5, 1, 1, 0, 0, 16'h0003, 16'h0004, 12, 1));
        apply(mk(0, 1, 16'h2115, 16'h0008, 16'h0009, 0, 0, 1, 1, 0, 1, 16'h0008, 16'h0009, 1, 1));

        // set and clear of pend[9] in one cycle: set wins
        apply(mk(0, 1, 16'h2190, 16'h0001, 16'h0002, 1, 9, 1, 1, 0, 1, 16'h0001, 16'h0002, 1, 9));
        apply(mk(0, 1, 16'h22A9, 16'h0005, 16'h0006, 0, 0, 0, 0, 0, 1, 16'h0001, 16'h0002, 1, 9));

        // reset drops an accept and clears every pending bit
        apply(mk(1, 1, 16'h21C2, 16'h0077, 16'h0000, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0));
        apply(mk(0, 1, 16'h2231, 16'h000C, 16'h000D, 0, 0, 1, 1, 0, 1, 16'h000C, 16'h000D, 2, 3));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
